dmem_responder: RTL

- Memory-side responder for the MIPS core's data-memory interface: takes the core's load/store requests (address, write data, write strobe) and returns read data.
- Adds a parameterised wait-state handshake (ready/error), so the core can be run against slow memory.
- Sits between the core's data port and the word-addressed data RAM, inside the top-level wrapper.

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_ram.sv | 26 ++
 rtl/dmem_responder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder slice.
//   state_e    : responder FSM states
//   op_e       : latched operation type
//   WORD_BYTES : bytes per memory word
//   addr_fault : flags misaligned or out-of-range byte addresses
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  localparam int unsigned WORD_BYTES = 4;

  // True when adr is not word aligned or lies beyond a 2^addr_bits-word memory.
  function automatic logic addr_fault(input logic [31:0] adr, input int unsigned addr_bits);
    logic misaligned;
    logic out_of_range;
    misaligned   = (adr % WORD_BYTES) != 32'd0;
    out_of_range = (adr >> (addr_bits + 2)) != 32'd0;
    return misaligned | out_of_range;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-addressed single-port data RAM, 2^ADDR_BITS x 32.
//   clk     : write clock
//   we_i    : synchronous write enable
//   addr_i  : word index
//   wdata_i : write data
//   rdata_o : combinational read data at addr_i
// Contents are intentionally not reset.
module dmem_ram #(
  parameter int unsigned ADDR_BITS = 6
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem_q [0:(1 << ADDR_BITS) - 1];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data port with configurable wait states.
//   clk, reset          : clock, asynchronous active-high reset
//   memread, memwrite   : load / store request, held until ready
//   adr, writedata      : byte address and store data
//   readdata            : data of the last successful load
//   ready               : one-cycle completion pulse
//   error               : fault pulse, coincident with ready
//   busy                : transaction in flight (acceptance through ready)
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 6,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        error,
  output logic        busy
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e                state_q, state_d;
  logic                  pend_q, pend_d;
  logic [3:0]            cnt_q, cnt_d;
  op_e                   op_q, op_d;
  logic                  fault_q, fault_d;
  logic [ADDR_BITS-1:0]  idx_q, idx_d;
  logic [31:0]           wd_q, wd_d;
  logic [31:0]           readdata_q, readdata_d;

  logic                  ram_we;
  logic [31:0]           ram_rdata;

  dmem_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (idx_q),
    .wdata_i (wd_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      op_q       <= OP_RD;
      fault_q    <= 1'b0;
      idx_q      <= '0;
      wd_q       <= '0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      fault_q    <= fault_d;
      idx_q      <= idx_d;
      wd_q       <= wd_d;
      readdata_q <= readdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    fault_d    = fault_q;
    idx_d      = idx_q;
    wd_d       = wd_q;
    readdata_d = readdata_q;
    ram_we     = 1'b0;

    case (state_q)
      IDLE: begin
        // pend_q marks the cycle after the accepting edge: the request is
        // latched but the wait/response sequence starts one edge later.
        if (pend_q) begin
          pend_d = 1'b0;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = RESP;
          end
        end else if (memread | memwrite) begin
          pend_d  = 1'b1;
          op_d    = memwrite ? OP_WR : OP_RD;
          fault_d = addr_fault(adr, ADDR_BITS) | (memread & memwrite);
          idx_d   = adr[ADDR_BITS+1:2];
          wd_d    = writedata;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // RAM write and load capture happen only on the edge entering RESP.
    if (state_d == RESP && state_q != RESP && !fault_q) begin
      if (op_q == OP_WR) ram_we     = 1'b1;
      else               readdata_d = ram_rdata;
    end
  end

  assign readdata = readdata_q;
  assign ready    = (state_q == RESP);
  assign error    = (state_q == RESP) & fault_q;
  assign busy     = pend_q | (state_q != IDLE);

endmodule
